netdma_desc_writer: RTL and testbench



---
 rtl/netdma_desc_pkg.sv | 26 ++
 rtl/netdma_desc_fifo.sv | 60 ++++++
 rtl/netdma_desc_writer.sv | 155 +++++++++++++++
 tb/tb_netdma_desc_writer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/netdma_desc_pkg.sv
// Shared constants and types for the netdma descriptor writer.
// CSR map, CTRL/STATUS bit positions and the staging state encoding.
package netdma_desc_pkg;

   localparam logic [1:0] CSR_ADDR   = 2'd0;
   localparam logic [1:0] CSR_LEN    = 2'd1;
   localparam logic [1:0] CSR_CTRL   = 2'd2;
   localparam logic [1:0] CSR_STATUS = 2'd3;

   localparam int CTRL_COMMIT  = 0;
   localparam int CTRL_GO      = 1;
   localparam int CTRL_CLR_ERR = 2;
   localparam int CTRL_IRQ_ACK = 3;

   localparam int ST_FULL    = 16;
   localparam int ST_EMPTY   = 17;
   localparam int ST_GO      = 18;
   localparam int ST_ERR_SEQ = 19;
   localparam int ST_ERR_LEN = 20;
   localparam int ST_ERR_OVF = 21;
   localparam int ST_ERR_UDF = 22;
   localparam int ST_IRQ     = 23;

   typedef enum logic [1:0] {STG_EMPTY, STG_ADDR, STG_LEN, STG_FULL} stg_state_t;

endpackage

// File: rtl/netdma_desc_fifo.sv
// Show-ahead synchronous FIFO: rdata_o always presents the head entry.
// Head reads as zero while empty so the output is clean out of reset.
module netdma_desc_fifo #(
   parameter int DEPTH  = 8,
   parameter int DESC_W = 48
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   wrreq_i,
   input  logic [DESC_W-1:0]      wdata_i,
   input  logic                   rdreq_i,
   output logic [DESC_W-1:0]      rdata_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic [$clog2(DEPTH):0] usedw_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DESC_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              push, pop;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign usedw_o = cnt_q;
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
   assign push    = wrreq_i && !full_o;
   assign pop     = rdreq_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      cnt_d    = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is not reset; the count gates visibility of stale entries.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/netdma_desc_writer.sv
// Host-side descriptor producer: CSR staging, commit into FIFO, sticky errors.
// Optional drain interrupt enabled by defining NETDMA_DESC_IRQ_EN.
module netdma_desc_writer
   import netdma_desc_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16,
   parameter int DEPTH  = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [1:0]                csr_address_i,
   input  logic                      csr_write_i,
   input  logic [31:0]               csr_writedata_i,
   input  logic                      csr_read_i,
   output logic [31:0]               csr_readdata_o,
   input  logic                      desc_rdreq_i,
   output logic [ADDR_W+LEN_W-1:0]   desc_data_o,
   output logic                      desc_empty_o,
   output logic                      go_o
`ifdef NETDMA_DESC_IRQ_EN
   ,
   output logic                      irq_o
`endif
);
   localparam int DESC_W = ADDR_W + LEN_W;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
   } desc_t;

   stg_state_t        stg_q, stg_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              go_q, go_d;
   logic [3:0]        err_q, err_d, err_set;   // {udf, ovf, len, seq}
   logic [31:0]       rdata_q, rdata_d, status;
   logic              fifo_full, fifo_empty;
   logic [CNT_W-1:0]  usedw;
   logic              wr_addr, wr_len, wr_ctrl, commit, push;
   desc_t             wdesc;

   assign wr_addr = csr_write_i && (csr_address_i == CSR_ADDR);
   assign wr_len  = csr_write_i && (csr_address_i == CSR_LEN);
   assign wr_ctrl = csr_write_i && (csr_address_i == CSR_CTRL);
   assign commit  = wr_ctrl && csr_writedata_i[CTRL_COMMIT];
   assign push    = commit && (stg_q == STG_FULL) && (len_q != '0) && !fifo_full;
   assign wdesc   = '{addr: addr_q, len: len_q};

   // One error cause per rejected commit: sequence, then length, then overflow.
   assign err_set[0] = commit && (stg_q != STG_FULL);
   assign err_set[1] = commit && (stg_q == STG_FULL) && (len_q == '0);
   assign err_set[2] = commit && (stg_q == STG_FULL) && (len_q != '0) && fifo_full;
   assign err_set[3] = desc_rdreq_i && fifo_empty;

   netdma_desc_fifo #(.DEPTH(DEPTH), .DESC_W(DESC_W)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .wrreq_i (push),
      .wdata_i (wdesc),
      .rdreq_i (desc_rdreq_i),
      .rdata_o (desc_data_o),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .usedw_o (usedw)
   );

`ifdef NETDMA_DESC_IRQ_EN
   logic irq_q, irq_d;
   always_comb begin
      irq_d = irq_q;
      if (wr_ctrl && csr_writedata_i[CTRL_IRQ_ACK]) irq_d = 1'b0;
      // Drain edge: last entry leaves with no refill in the same cycle.
      if (desc_rdreq_i && (usedw == CNT_W'(1)) && !push && go_q) irq_d = 1'b1;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) irq_q <= 1'b0;
      else       irq_q <= irq_d;
   end
   assign irq_o = irq_q;
`endif

   always_comb begin
      status                = '0;
      status[CNT_W-1:0]     = usedw;
      status[ST_FULL]       = fifo_full;
      status[ST_EMPTY]      = fifo_empty;
      status[ST_GO]         = go_q;
      status[ST_ERR_SEQ]    = err_q[0];
      status[ST_ERR_LEN]    = err_q[1];
      status[ST_ERR_OVF]    = err_q[2];
      status[ST_ERR_UDF]    = err_q[3];
`ifdef NETDMA_DESC_IRQ_EN
      status[ST_IRQ]        = irq_q;
`endif
   end

   always_comb begin
      stg_d   = stg_q;
      addr_d  = addr_q;
      len_d   = len_q;
      go_d    = go_q;
      err_d   = err_q;
      rdata_d = '0;
      if (push) stg_d = STG_EMPTY;
      if (wr_addr) begin
         addr_d = csr_writedata_i[ADDR_W-1:0];
         if (stg_q == STG_EMPTY)    stg_d = STG_ADDR;
         else if (stg_q == STG_LEN) stg_d = STG_FULL;
      end
      if (wr_len) begin
         len_d = csr_writedata_i[LEN_W-1:0];
         if (stg_q == STG_EMPTY)     stg_d = STG_LEN;
         else if (stg_q == STG_ADDR) stg_d = STG_FULL;
      end
      if (wr_ctrl) begin
         go_d = csr_writedata_i[CTRL_GO];
         if (csr_writedata_i[CTRL_CLR_ERR]) err_d = '0;
      end
      err_d = err_d | err_set;
      if (csr_read_i) begin
         case (csr_address_i)
            CSR_ADDR: rdata_d = 32'(addr_q);
            CSR_LEN:  rdata_d = 32'(len_q);
            CSR_CTRL: rdata_d = {30'd0, go_q, 1'b0};
            default:  rdata_d = status;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stg_q   <= STG_EMPTY;
         addr_q  <= '0;
         len_q   <= '0;
         go_q    <= 1'b0;
         err_q   <= '0;
         rdata_q <= '0;
      end else begin
         stg_q   <= stg_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         go_q    <= go_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign csr_readdata_o = rdata_q;
   assign desc_empty_o   = fifo_empty;
   assign go_o           = go_q;

endmodule

// File: tb/tb_netdma_desc_writer.sv
// Directed bench for netdma_desc_writer with a queue-based reference model.
// Build with NETDMA_DESC_IRQ_EN defined to also exercise the drain interrupt.
module tb_netdma_desc_writer;
   localparam int DEPTH = 8;
   localparam logic [31:0] NO_IRQ = 32'hFF7F_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  csr_address;
   logic        csr_write, csr_read, desc_rdreq;
   logic [31:0] csr_writedata, csr_readdata;
   logic [47:0] desc_data;
   logic        desc_empty, go;
`ifdef NETDMA_DESC_IRQ_EN
   logic        irq;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   netdma_desc_writer dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .csr_address_i   (csr_address),
      .csr_write_i     (csr_write),
      .csr_writedata_i (csr_writedata),
      .csr_read_i      (csr_read),
      .csr_readdata_o  (csr_readdata),
      .desc_rdreq_i    (desc_rdreq),
      .desc_data_o     (desc_data),
      .desc_empty_o    (desc_empty),
      .go_o            (go)
`ifdef NETDMA_DESC_IRQ_EN
      ,
      .irq_o           (irq)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: staged-field flags plus a queue of committed descriptors.
   logic [47:0] m_q[$];
   bit          m_ha, m_hl, m_go, m_seq, m_lenerr, m_ovf, m_udf, m_irq;
   logic [31:0] m_addr, m_rdata;
   logic [15:0] m_len;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   task automatic model_step();
      int          sz;
      bit          commit, push, pop, ctrl;
      logic [31:0] st;
      sz = m_q.size();
      if (rst) begin
         m_q.delete();
         {m_ha, m_hl, m_go, m_seq, m_lenerr, m_ovf, m_udf, m_irq} = '0;
         m_addr = '0; m_len = '0; m_rdata = '0;
         return;
      end
      st = 32'(sz);
      st[16] = (sz == DEPTH); st[17] = (sz == 0); st[18] = m_go;
      st[19] = m_seq; st[20] = m_lenerr; st[21] = m_ovf; st[22] = m_udf; st[23] = m_irq;
      m_rdata = '0;
      if (csr_read)
         case (csr_address)
            2'd0: m_rdata = m_addr;
            2'd1: m_rdata = {16'd0, m_len};
            2'd2: m_rdata = {30'd0, m_go, 1'b0};
            default: m_rdata = st;
         endcase
      ctrl   = csr_write && csr_address == 2'd2;
      commit = ctrl && csr_writedata[0];
      push   = commit && m_ha && m_hl && m_len != 0 && sz < DEPTH;
      pop    = desc_rdreq && sz > 0;
      if (ctrl && csr_writedata[2]) {m_seq, m_lenerr, m_ovf, m_udf} = '0;
      if (commit && !(m_ha && m_hl)) m_seq = 1;
      else if (commit && m_len == 0) m_lenerr = 1;
      else if (commit && sz == DEPTH) m_ovf = 1;
      if (desc_rdreq && sz == 0) m_udf = 1;
`ifdef NETDMA_DESC_IRQ_EN
      if (ctrl && csr_writedata[3]) m_irq = 0;
      if (pop && sz == 1 && !push && m_go) m_irq = 1;
`endif
      if (ctrl) m_go = csr_writedata[1];
      if (pop) void'(m_q.pop_front());
      if (push) begin
         m_q.push_back({m_addr, m_len});
         m_ha = 0; m_hl = 0;
      end
      if (csr_write && csr_address == 2'd0) begin m_addr = csr_writedata; m_ha = 1; end
      if (csr_write && csr_address == 2'd1) begin m_len = csr_writedata[15:0]; m_hl = 1; end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("desc_empty", desc_empty, m_q.size() == 0);
         chk("desc_data", desc_data, (m_q.size() > 0) ? m_q[0] : 48'd0);
         chk("go", go, m_go);
         chk("readdata", csr_readdata, m_rdata);
`ifdef NETDMA_DESC_IRQ_EN
         chk("irq", irq, m_irq);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      csr_write = 0; csr_read = 0; desc_rdreq = 0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      csr_address = a; csr_writedata = d; csr_write = 1;
      tick();
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      csr_address = a; csr_read = 1;
      tick();
      v = csr_readdata;
   endtask

   task automatic pop();
      desc_rdreq = 1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      rst = 1; csr_address = 0; csr_write = 0; csr_read = 0;
      csr_writedata = 0; desc_rdreq = 0;
      tick(); chk_en = 1; tick();
      rst = 0;
      rd(2'd3, v); chk("reset_status", v, 32'h0002_0000);

      // Basic commit with go
      wr(2'd0, 32'h1000_0000); wr(2'd1, 32'h40); wr(2'd2, 32'h3);
      chk("t1_empty", desc_empty, 1'b0);
      chk("t1_data", desc_data, 48'h1000_0000_0040);
      chk("t1_go", go, 1'b1);
      rd(2'd3, v); chk("t1_status", v & NO_IRQ, 32'h0004_0001);

      // Reverse staging order, upper LEN bits ignored
      wr(2'd1, 32'hFFFF_0080); wr(2'd0, 32'h2000); wr(2'd2, 32'h3);
      rd(2'd1, v); chk("len_readback", v, 32'h0000_0080);
      wr(2'd0, 32'h3000); wr(2'd2, 32'h3);
      rd(2'd3, v); chk("seq_status", v & NO_IRQ, 32'h000C_0002);
      rd(2'd0, v); chk("addr_readback", v, 32'h0000_3000);
      wr(2'd1, 32'h0); wr(2'd2, 32'h3);
      rd(2'd3, v); chk("len_err_status", v & NO_IRQ, 32'h001C_0002);
      rd(2'd2, v); chk("ctrl_readback", v, 32'h0000_0002);
      wr(2'd2, 32'hE);
      rd(2'd3, v); chk("clr_status", v & NO_IRQ, 32'h0004_0002);
      pop(); pop();

      // Fill to DEPTH, then a 9th commit with a same-cycle pop
      for (int i = 0; i < DEPTH; i++) begin
         wr(2'd0, 32'hA000 + 32'(i) * 32'h100); wr(2'd1, 32'(i + 1)); wr(2'd2, 32'h3);
      end
      rd(2'd3, v); chk("full_status", v & NO_IRQ, 32'h0005_0008);
      wr(2'd0, 32'hBEEF); wr(2'd1, 32'h9);
      desc_rdreq = 1; wr(2'd2, 32'h3);
      rd(2'd3, v); chk("ovf_status", v & NO_IRQ, 32'h0024_0007);
      chk("ovf_head", desc_data, 48'h0000_A100_0002);
      for (int i = 0; i < DEPTH - 1; i++) pop();

      // Underflow, then clear errors (go drops too)
      pop();
      rd(2'd3, v); chk("udf_status", v & NO_IRQ, 32'h0066_0000);
      wr(2'd2, 32'hC);
      rd(2'd3, v); chk("clr_all_status", v, 32'h0002_0000);
      chk("go_off", go, 1'b0);

      // Push and pop in the same cycle keeps count and order
      wr(2'd2, 32'h2);
      wr(2'd0, 32'hC000); wr(2'd1, 32'h5); wr(2'd2, 32'h3);
      wr(2'd0, 32'hD000); wr(2'd1, 32'h6);
      desc_rdreq = 1; wr(2'd2, 32'h3);
      chk("pushpop_head", desc_data, 48'h0000_D000_0006);
      rd(2'd3, v); chk("pushpop_status", v & NO_IRQ, 32'h0004_0001);

      // Reset mid-operation with 5 entries and a partial stage
      for (int i = 0; i < 4; i++) begin
         wr(2'd0, 32'hE000 + 32'(i)); wr(2'd1, 32'h10); wr(2'd2, 32'h3);
      end
      wr(2'd0, 32'hF000);
      rd(2'd3, v); chk("pre_rst_status", v & NO_IRQ, 32'h0004_0005);
      rst = 1; tick(); rst = 0;
      chk("rst_empty", desc_empty, 1'b1);
      chk("rst_go", go, 1'b0);
      rd(2'd3, v); chk("rst_mid_status", v, 32'h0002_0000);
      rd(2'd0, v); chk("rst_addr", v, 32'h0);

`ifdef NETDMA_DESC_IRQ_EN
      wr(2'd2, 32'h2);
      wr(2'd0, 32'h5000); wr(2'd1, 32'h8); wr(2'd2, 32'h3);
      pop();
      chk("irq_set", irq, 1'b1);
      wr(2'd2, 32'hA);
      chk("irq_ack", irq, 1'b0);
      chk("irq_ack_go", go, 1'b1);
`endif
      tick(); tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
